// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate sequencer: op select codes and FSM states.
// The instruction decoder imports the same op codes.
package shift_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_ZERO = 3'b011;
    localparam logic [2:0] OP_RCL  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_RCR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Only the rotate-through-carry ops expose the carry on CO.
    function automatic logic is_carry_op(input logic [2:0] op);
        return (op == OP_RCL) || (op == OP_RCR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step: (acc, carry, op) -> (acc', carry').
// Purely combinational; the sequencer applies it once per clock.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic             i_carry,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_carry
);

    always_comb begin
        o_acc   = i_acc;
        o_carry = i_carry;
        case (i_op)
            OP_PASS: o_acc = i_acc;
            OP_SHL:  o_acc = {i_acc[WIDTH-2:0], 1'b0};
            OP_SHR:  o_acc = {1'b0, i_acc[WIDTH-1:1]};
            OP_ZERO: o_acc = '0;
            OP_ROL:  o_acc = {i_acc[WIDTH-2:0], i_acc[WIDTH-1]};
            OP_ROR:  o_acc = {i_acc[0], i_acc[WIDTH-1:1]};
            // Carry acts as a (WIDTH+1)-th bit of the rotated word.
            OP_RCL: begin
                o_acc   = {i_acc[WIDTH-2:0], i_carry};
                o_carry = i_acc[WIDTH-1];
            end
            OP_RCR: begin
                o_acc   = {i_carry, i_acc[WIDTH-1:1]};
                o_carry = i_acc[0];
            end
            default: o_acc = i_acc;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: applies one single-bit op AMT times,
// one step per clock, chaining the carry, then pulses DONE.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_hsel,
    input  logic [AMT_W-1:0] i_amt,
    input  logic [WIDTH-1:0] i_f,
    input  logic             i_ci,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_s,
    output logic             o_co
);

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [AMT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_acc_step;
    logic             w_carry_step;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .i_acc   (r_acc),
        .i_carry (r_carry),
        .i_op    (r_op),
        .o_acc   (w_acc_step),
        .o_carry (w_carry_step)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_PASS;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (i_start) begin
                        r_acc   <= i_f;
                        r_op    <= i_hsel;
                        // Non-carry ops keep the carry at 0 so CO can follow it directly.
                        r_carry <= is_carry_op(i_hsel) ? i_ci : 1'b0;
                        r_cnt   <= i_amt;
                        if (i_amt == '0) begin
                            r_state <= ST_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_step;
                    r_carry <= w_carry_step;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == AMT_W'(1)) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_s    = r_acc;
    assign o_co   = r_carry;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed table, hand-written multi-cycle sequences,
// and random ops checked against an arithmetic rotate/shift model.
module tb_shift_sequencer;

    localparam int W = 8;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   hsel = '0;
    logic [A-1:0] amt = '0;
    logic [W-1:0] f = '0;
    logic         ci = 1'b0;
    logic         busy, done, co;
    logic [W-1:0] s;

    int n_vec = 0;
    int n_err = 0;

    shift_sequencer #(.WIDTH(W), .AMT_W(A)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_hsel  (hsel),
        .i_amt   (amt),
        .i_f     (f),
        .i_ci    (ci),
        .o_busy  (busy),
        .o_done  (done),
        .o_s     (s),
        .o_co    (co)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] f;
        logic [2:0]   hsel;
        logic [A-1:0] amt;
        logic         ci;
        logic [W-1:0] exp_s;
        logic         exp_co;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Result of AMT single-bit steps, computed as one whole-word shift or rotate.
    function automatic void model(input logic [W-1:0] mf, input logic [2:0] mh,
                                  input logic [A-1:0] ma, input logic mci,
                                  output logic [W-1:0] ms, output logic mco);
        int n;
        logic [W:0] v;
        ms  = mf;
        mco = 1'b0;
        case (mh)
            3'b000: ms = mf;
            3'b001: ms = (int'(ma) >= W) ? '0 : W'(mf << ma);
            3'b010: ms = (int'(ma) >= W) ? '0 : W'(mf >> ma);
            3'b011: ms = (ma == 0) ? mf : '0;
            3'b101: begin n = int'(ma) % W; ms = (mf << n) | (mf >> (W - n)); end
            3'b110: begin n = int'(ma) % W; ms = (mf >> n) | (mf << (W - n)); end
            3'b100: begin
                n = int'(ma) % (W + 1);
                v = {mf, mci};
                v = (v << n) | (v >> (W + 1 - n));
                ms = v[W:1]; mco = v[0];
            end
            default: begin
                n = int'(ma) % (W + 1);
                v = {mf, mci};
                v = (v >> n) | (v << (W + 1 - n));
                ms = v[W:1]; mco = v[0];
            end
        endcase
    endfunction

    // Waits (bounded) for DONE, counting BUSY cycles seen beforehand.
    task automatic wait_done(output int bc, output bit seen);
        bc = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] xf, input logic [2:0] xh,
                          input logic [A-1:0] xa, input logic xci,
                          input logic [W-1:0] es, input logic eco);
        int bc;
        bit seen;
        logic [W-1:0] s_at_done;
        @(negedge clk);
        f = xf; hsel = xh; amt = xa; ci = xci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        f = ~xf;
        wait_done(bc, seen);
        $display("op %s f=%02h hsel=%0d amt=%0d ci=%0d -> s=%02h co=%0d busy_cycles=%0d",
                 name, xf, xh, xa, xci, s, co, bc);
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_busy_cycles"}, 32'(bc), 32'(xa));
        chk({name, "_s"}, 32'(s), 32'(es));
        chk({name, "_co"}, 32'(co), 32'(eco));
        s_at_done = s;
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
        chk({name, "_s_held"}, 32'(s), 32'(s_at_done));
    endtask

    vec_t tbl[15];

    initial begin
        int bc;
        bit seen;
        int dcount;
        logic [W-1:0] es;
        logic eco;
        logic [W-1:0] rf;
        logic [2:0] rh;
        logic [A-1:0] ra;
        logic rci;

        tbl[0]  = '{8'h81, 3'b101, 4'd3,  1'b0, 8'h0C, 1'b0};
        tbl[1]  = '{8'h80, 3'b100, 4'd1,  1'b0, 8'h00, 1'b1};
        tbl[2]  = '{8'h80, 3'b100, 4'd9,  1'b0, 8'h80, 1'b0};
        tbl[3]  = '{8'h01, 3'b111, 4'd2,  1'b1, 8'hC0, 1'b0};
        tbl[4]  = '{8'hFF, 3'b001, 4'd8,  1'b0, 8'h00, 1'b0};
        tbl[5]  = '{8'hF0, 3'b010, 4'd4,  1'b0, 8'h0F, 1'b0};
        tbl[6]  = '{8'h5A, 3'b000, 4'd0,  1'b0, 8'h5A, 1'b0};
        tbl[7]  = '{8'h3C, 3'b100, 4'd0,  1'b1, 8'h3C, 1'b1};
        tbl[8]  = '{8'hA5, 3'b101, 4'd8,  1'b0, 8'hA5, 1'b0};
        tbl[9]  = '{8'h01, 3'b001, 4'd7,  1'b1, 8'h80, 1'b0};
        tbl[10] = '{8'h77, 3'b011, 4'd1,  1'b0, 8'h00, 1'b0};
        tbl[11] = '{8'h01, 3'b110, 4'd1,  1'b0, 8'h80, 1'b0};
        tbl[12] = '{8'hFF, 3'b010, 4'd15, 1'b0, 8'h00, 1'b0};
        tbl[13] = '{8'h00, 3'b111, 4'd9,  1'b1, 8'h00, 1'b1};
        tbl[14] = '{8'h12, 3'b110, 4'd0,  1'b1, 8'h12, 1'b0};

        // Reset state
        #12;
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            run_op($sformatf("tbl%0d", i), tbl[i].f, tbl[i].hsel, tbl[i].amt, tbl[i].ci,
                   tbl[i].exp_s, tbl[i].exp_co);

        // START pulsed mid-RUN is ignored
        @(negedge clk);
        f = 8'h81; hsel = 3'b101; amt = 4'd3; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b1; f = 8'hFF; hsel = 3'b011; amt = 4'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, seen);
        $display("seq midrun_start -> s=%02h co=%0d busy_cycles=%0d", s, co, bc + 1);
        chk("midrun_done_seen", 32'(seen), 32'd1);
        chk("midrun_busy_cycles", 32'(bc + 1), 32'd3);
        chk("midrun_s", 32'(s), 32'h0C);
        chk("midrun_co", 32'(co), 32'd0);

        // Back-to-back: START during FIN enters RUN with no IDLE cycle
        @(negedge clk);
        @(negedge clk);
        f = 8'h01; hsel = 3'b001; amt = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, seen);
        chk("b2b_first_s", 32'(s), 32'h04);
        f = 8'h01; hsel = 3'b110; amt = 4'd2; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_now", 32'(busy), 32'd1);
        chk("b2b_done_low", 32'(done), 32'd0);
        wait_done(bc, seen);
        $display("seq back_to_back -> s=%02h co=%0d busy_cycles=%0d", s, co, bc);
        chk("b2b_done_seen", 32'(seen), 32'd1);
        chk("b2b_busy_cycles", 32'(bc), 32'd2);
        chk("b2b_s", 32'(s), 32'h40);

        // Asynchronous reset during cycle 2 of an AMT=7 run
        @(negedge clk);
        f = 8'h81; hsel = 3'b100; amt = 4'd7; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("seq async_reset -> s=%02h co=%0d busy=%0d done=%0d", s, co, busy, done);
        chk("arst_s", 32'(s), 32'd0);
        chk("arst_co", 32'(co), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("arst_no_resume", 32'(dcount), 32'd0);

        // Random ops against the model
        for (int i = 0; i < 60; i++) begin
            rf  = W'($urandom);
            rh  = 3'($urandom_range(0, 7));
            ra  = A'($urandom_range(0, 15));
            rci = 1'($urandom);
            model(rf, rh, ra, rci, es, eco);
            run_op($sformatf("rnd%0d", i), rf, rh, ra, rci, es, eco);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
